// File: rtl/btb_update_if.sv
// Branch-resolution handshake between EX (master) and the BTB write side (slave).
interface btb_update_if;
   logic        update_valid;
   logic        update_ready;
   logic [31:0] update_pc;
   logic [31:0] update_target;
   logic        update_taken;
   logic        update_done;

   modport master (
      output update_valid, update_pc, update_target, update_taken,
      input  update_ready, update_done
   );

   modport slave (
      input  update_valid, update_pc, update_target, update_taken,
      output update_ready, update_done
   );
endinterface

// File: rtl/btb_update.sv
// Write/owner side of an 8-set, 2-way BTB: set storage, per-set LRU, 2-cycle read-modify-write.
// Optional macro BTB_FLUSH_EN adds a 'flush' input that invalidates all entries and aborts a pending write.
//
// state | meaning
// IDLE  | ready for a resolution; captures pc/target/taken on valid&&ready
// WRITE | read-modify-write of the captured set; commits and pulses update_done
module btb_update #(
   parameter int         NUM_SETS = 8,
   parameter logic [1:0] ALLOC_ST = 2'b11
) (
   input  logic                clk,
   input  logic                rst_n,
`ifdef BTB_FLUSH_EN
   input  logic                flush,
`endif
   input  logic [2:0]          read_index,
   output logic [127:0]        read_set,
   output logic [NUM_SETS-1:0] LRU,
   input  logic                read_en,
   input  logic                next_LRU_read,
   btb_update_if.slave         upd
);

   typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

   state_t       state, state_nxt;
   logic [127:0] storage [NUM_SETS];

   logic [26:0]  req_tag;
   logic [2:0]   req_idx;
   logic [31:0]  req_target;
   logic         req_taken;

   logic         flush_i;
   logic         accept;
   logic         commit;

   logic [127:0] cur_set, new_set;
   logic [63:0]  way1, way2;
   logic         hit1, hit2;
   logic         do_write;
   logic         wr_way;

   logic         unused_pc_bits;
   assign unused_pc_bits = ^upd.update_pc[1:0];

`ifdef BTB_FLUSH_EN
   assign flush_i = flush;
`else
   assign flush_i = 1'b0;
`endif

   function automatic logic [1:0] pred_next(input logic [1:0] st, input logic taken);
      if (taken) pred_next = (st == 2'b00) ? 2'b01 : 2'b10;
      else       pred_next = (st == 2'b10) ? 2'b11 : 2'b00;
   endfunction

   assign read_set = storage[read_index];

   assign accept = upd.update_valid && upd.update_ready;
   assign commit = (state == WRITE) && !flush_i;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      if (flush_i) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept) state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // outputs
   always_comb begin
      upd.update_ready = (state == IDLE) && !flush_i;
      upd.update_done  = commit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_tag    <= '0;
         req_idx    <= '0;
         req_target <= '0;
         req_taken  <= 1'b0;
      end else if (accept) begin
         req_tag    <= upd.update_pc[31:5];
         req_idx    <= upd.update_pc[4:2];
         req_target <= upd.update_target;
         req_taken  <= upd.update_taken;
      end
   end

   assign cur_set = storage[req_idx];
   assign way1    = cur_set[127:64];
   assign way2    = cur_set[63:0];
   assign hit1    = way1[63] && (way1[62:36] == req_tag);
   assign hit2    = !hit1 && way2[63] && (way2[62:36] == req_tag);

   // Hits always rewrite the way (state may change); misses only allocate when taken.
   always_comb begin
      new_set  = cur_set;
      do_write = 1'b0;
      wr_way   = 1'b0;
      if (hit1) begin
         do_write        = 1'b1;
         wr_way          = 1'b0;
         new_set[127:64] = {1'b1, req_tag, req_taken ? req_target : way1[35:4],
                            pred_next(way1[3:2], req_taken), 2'b00};
      end else if (hit2) begin
         do_write       = 1'b1;
         wr_way         = 1'b1;
         new_set[63:0]  = {1'b1, req_tag, req_taken ? req_target : way2[35:4],
                           pred_next(way2[3:2], req_taken), 2'b00};
      end else if (req_taken) begin
         do_write = 1'b1;
         if (!way1[63])      wr_way = 1'b0;
         else if (!way2[63]) wr_way = 1'b1;
         else                wr_way = ~LRU[req_idx];
         if (wr_way) new_set[63:0]   = {1'b1, req_tag, req_target, ALLOC_ST, 2'b00};
         else        new_set[127:64] = {1'b1, req_tag, req_target, ALLOC_ST, 2'b00};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SETS; i++) storage[i] <= '0;
      end else if (flush_i) begin
         for (int i = 0; i < NUM_SETS; i++) begin
            storage[i][127] <= 1'b0;
            storage[i][63]  <= 1'b0;
         end
      end else if (commit && do_write) begin
         storage[req_idx] <= new_set;
      end
   end

   // The write-side assignment is last so it wins a same-index collision with the IF update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         LRU <= '0;
      end else if (flush_i) begin
         LRU <= '0;
      end else begin
         if (read_en)           LRU[read_index] <= next_LRU_read;
         if (commit && do_write) LRU[req_idx]   <= wr_way;
      end
   end

endmodule

// File: tb/tb_btb_update.sv
// Scoreboard bench for btb_update: directed resolutions, monitor checks the committed set and LRU.
module tb_btb_update;

   typedef struct packed {
      logic [2:0]   idx;
      logic [127:0] set;
      logic [7:0]   lru;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         flush;
   logic [2:0]   read_index;
   logic [127:0] read_set;
   logic [7:0]   lru;
   logic         read_en;
   logic         next_LRU_read;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];

   btb_update_if upd_if ();

   btb_update dut (
      .clk           (clk),
      .rst_n         (rst_n),
`ifdef BTB_FLUSH_EN
      .flush         (flush),
`endif
      .read_index    (read_index),
      .read_set      (read_set),
      .LRU           (lru),
      .read_en       (read_en),
      .next_LRU_read (next_LRU_read),
      .upd           (upd_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] mk(input logic v, input logic [26:0] tag,
                                      input logic [31:0] tgt, input logic [1:0] st);
      return {v, tag, tgt, st, 2'b00};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: each update_done pops one expectation and checks the set once the write has landed.
   always @(negedge clk) begin
      if (rst_n && upd_if.update_done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 1'b1, 1'b0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            @(negedge clk);
            chk("index_held", {125'b0, read_index}, {125'b0, e.idx});
            chk("committed_set", read_set, e.set);
            chk("committed_lru", {120'b0, lru}, {120'b0, e.lru});
            chk("done_one_cycle", {127'b0, upd_if.update_done}, 128'b0);
         end
      end
   end

   task automatic wait_ready();
      int n;
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (upd_if.update_ready) break;
      end
      if (n == 20) chk("ready_timeout", 1'b0, 1'b1);
   endtask

   task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                            input logic [127:0] exp_set, input logic [7:0] exp_lru,
                            input logic collide, input logic [127:0] old_set);
      exp_t e;
      @(posedge clk); #1;
      upd_if.update_valid  = 1'b1;
      upd_if.update_pc     = pc;
      upd_if.update_target = tgt;
      upd_if.update_taken  = taken;
      read_index           = pc[4:2];
      e.idx = pc[4:2]; e.set = exp_set; e.lru = exp_lru;
      sb.push_back(e);
      wait_ready();
      @(posedge clk); #1;
      upd_if.update_valid = 1'b0;
      if (collide) begin
         read_en       = 1'b1;
         next_LRU_read = 1'b1;
         chk("no_bypass_old_data", read_set, old_set);
      end
      @(negedge clk);
      @(posedge clk); #1;
      read_en       = 1'b0;
      next_LRU_read = 1'b0;
      @(negedge clk);
   endtask

   logic [63:0] s1w1, s1w2;
   exp_t        e2;

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      read_index = 3'd0;
      read_en = 1'b0;
      next_LRU_read = 1'b0;
      upd_if.update_valid = 1'b0;
      upd_if.update_pc = '0;
      upd_if.update_target = '0;
      upd_if.update_taken = 1'b0;
      #12;
      for (int i = 0; i < 8; i++) begin
         read_index = 3'(i);
         #1 chk("reset_set", read_set, 128'b0);
      end
      chk("reset_lru", {120'b0, lru}, 128'b0);
      chk("reset_ready", {127'b0, upd_if.update_ready}, 128'b1);
      chk("reset_done", {127'b0, upd_if.update_done}, 128'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // allocation, then predictor walk 11->10->10->11->00
      s1w2 = 64'b0;
      s1w1 = mk(1'b1, 27'd8, 32'h200, 2'b11);
      do_update(32'h104, 32'h200, 1'b1, {s1w1, s1w2}, 8'h00, 1'b0, '0);
      s1w1 = mk(1'b1, 27'd8, 32'h200, 2'b10);
      do_update(32'h104, 32'h200, 1'b1, {s1w1, s1w2}, 8'h00, 1'b0, '0);
      do_update(32'h104, 32'h200, 1'b1, {s1w1, s1w2}, 8'h00, 1'b0, '0);
      s1w1 = mk(1'b1, 27'd8, 32'h200, 2'b11);
      do_update(32'h104, 32'h3FC, 1'b0, {s1w1, s1w2}, 8'h00, 1'b0, '0);
      s1w1 = mk(1'b1, 27'd8, 32'h200, 2'b00);
      do_update(32'h104, 32'h3FC, 1'b0, {s1w1, s1w2}, 8'h00, 1'b0, '0);

      // fill way2 of set1
      s1w2 = mk(1'b1, 27'd9, 32'h400, 2'b11);
      do_update(32'h124, 32'h400, 1'b1, {s1w1, s1w2}, 8'h02, 1'b0, '0);

      // IF lookup hits way1
      @(posedge clk); #1;
      read_index = 3'd1; read_en = 1'b1; next_LRU_read = 1'b0;
      chk("if_read_set", read_set, {s1w1, s1w2});
      @(posedge clk); #1;
      read_en = 1'b0;
      chk("if_lru_update", {120'b0, lru}, 128'h00);

      // victim replacement into way2, then a way2 hit
      s1w2 = mk(1'b1, 27'd10, 32'h500, 2'b11);
      do_update(32'h144, 32'h500, 1'b1, {s1w1, s1w2}, 8'h02, 1'b0, '0);
      s1w2 = mk(1'b1, 27'd10, 32'h540, 2'b10);
      do_update(32'h144, 32'h540, 1'b1, {s1w1, s1w2}, 8'h02, 1'b0, '0);

      // way1 hit while IF writes LRU[1]=1 in the same cycle: write side wins
      s1w1 = mk(1'b1, 27'd8, 32'h200, 2'b01);
      do_update(32'h104, 32'h200, 1'b1, {s1w1, s1w2}, 8'h00, 1'b1,
                {mk(1'b1, 27'd8, 32'h200, 2'b00), s1w2});

      // not-taken miss: no write, done still pulses
      do_update(32'h300, 32'h700, 1'b0, 128'b0, 8'h00, 1'b0, '0);

      // update_valid held across two requests
      @(posedge clk); #1;
      upd_if.update_valid = 1'b1; upd_if.update_pc = 32'h300;
      upd_if.update_target = 32'h700; upd_if.update_taken = 1'b0; read_index = 3'd0;
      e2.idx = 3'd0; e2.set = 128'b0; e2.lru = 8'h00;
      sb.push_back(e2);
      @(negedge clk);
      chk("held_ready_idle", {127'b0, upd_if.update_ready}, 128'b1);
      @(posedge clk); #1;
      upd_if.update_pc = 32'h300; upd_if.update_target = 32'h600; upd_if.update_taken = 1'b1;
      e2.set = {mk(1'b1, 27'h18, 32'h600, 2'b11), 64'b0};
      sb.push_back(e2);
      chk("held_ready_write", {127'b0, upd_if.update_ready}, 128'b0);
      @(posedge clk); #1;
      chk("held_ready_back", {127'b0, upd_if.update_ready}, 128'b1);
      @(posedge clk); #1;
      upd_if.update_valid = 1'b0;
      chk("held_second_accepted", {127'b0, upd_if.update_ready}, 128'b0);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);

      // reset during WRITE: dropped request, reset outputs
      @(posedge clk); #1;
      upd_if.update_valid = 1'b1; upd_if.update_pc = 32'h124;
      upd_if.update_target = 32'h999; upd_if.update_taken = 1'b1;
      @(posedge clk); #1;
      upd_if.update_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_done", {127'b0, upd_if.update_done}, 128'b0);
      chk("rst_mid_ready", {127'b0, upd_if.update_ready}, 128'b1);
      chk("rst_mid_lru", {120'b0, lru}, 128'b0);
      for (int i = 0; i < 8; i++) begin
         read_index = 3'(i);
         #1 chk("rst_mid_set", read_set, 128'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      read_index = 3'd1;
      #1 chk("rst_no_commit", read_set, 128'b0);

`ifdef BTB_FLUSH_EN
      do_update(32'h104, 32'h200, 1'b1, {mk(1'b1, 27'd8, 32'h200, 2'b11), 64'b0}, 8'h00, 1'b0, '0);
      @(posedge clk); #1;
      upd_if.update_valid = 1'b1; upd_if.update_pc = 32'h124;
      upd_if.update_target = 32'h400; upd_if.update_taken = 1'b1;
      @(posedge clk); #1;
      upd_if.update_valid = 1'b0;
      flush = 1'b1;
      #1 chk("flush_no_done", {127'b0, upd_if.update_done}, 128'b0);
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_ready", {127'b0, upd_if.update_ready}, 128'b1);
      chk("flush_lru", {120'b0, lru}, 128'b0);
      for (int i = 0; i < 8; i++) begin
         read_index = 3'(i);
         #1 chk("flush_valid", {126'b0, read_set[127], read_set[63]}, 128'b0);
      end
      @(negedge clk);
      @(negedge clk);
`endif

      for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
      chk("scoreboard_drained", 128'(sb.size()), 128'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
